// File: rtl/rv32i_memory_unit.sv
// Single-port memory subsystem for the multicycle RV32I core: instruction RAM,
// data RAM and a small MMIO window, with byte-enabled stores and extended loads.
module rv32i_memory_unit #(
    parameter int          INST_WORDS = 512,
    parameter int          DATA_WORDS = 512,
    parameter logic [31:0] INST_BASE  = 32'h0000_0000,
    parameter logic [31:0] DATA_BASE  = 32'h1000_0000,
    parameter logic [31:0] MMIO_BASE  = 32'hF000_0000,
    parameter string       INIT_INST  = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    input  logic        wr_ena,
    input  logic [2:0]  funct3,
    output logic [31:0] rd_data,
    output logic        misaligned,
    output logic        unmapped,
    output logic [15:0] leds
);

    localparam int          IW         = (INST_WORDS > 1) ? $clog2(INST_WORDS) : 1;
    localparam int          DW         = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;
    localparam logic [31:0] INST_BYTES = 32'(4 * INST_WORDS);
    localparam logic [31:0] DATA_BYTES = 32'(4 * DATA_WORDS);

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_INST,
        SEL_DATA,
        SEL_MMIO
    } sel_e;

    logic [31:0]   inst_off;
    logic [31:0]   data_off;
    logic          in_inst;
    logic          in_data;
    logic          in_mmio;
    logic          is_byte;
    logic          is_half;
    logic          align_bad;
    logic          mis_now;
    logic          unm_now;
    sel_e          sel_now;
    logic [3:0]    byte_en;
    logic [31:0]   store_word;
    logic          inst_we;
    logic          data_we;
    logic          leds_we;
    logic [IW-1:0] inst_idx;
    logic [DW-1:0] data_idx;
    logic [31:0]   mmio_rd;

    logic [31:0]   inst_mem [INST_WORDS];
    logic [31:0]   data_mem [DATA_WORDS];
    logic [31:0]   inst_word;
    logic [31:0]   data_word;
    logic [31:0]   mmio_word;
    logic [31:0]   cycles;
    sel_e          sel_q;
    logic [1:0]    lane_q;
    logic [2:0]    funct3_q;

    // Subtracting the base first lets one unsigned compare cover both bounds.
    assign inst_off = addr - INST_BASE;
    assign data_off = addr - DATA_BASE;
    assign in_inst  = inst_off < INST_BYTES;
    assign in_data  = data_off < DATA_BYTES;
    assign in_mmio  = addr[31:4] == MMIO_BASE[31:4];
    assign inst_idx = inst_off[IW+1:2];
    assign data_idx = data_off[DW+1:2];

    // funct3[1:0] alone selects the size; 011/110/111 fall through to word.
    assign is_byte   = funct3[1:0] == 2'b00;
    assign is_half   = funct3[1:0] == 2'b01;
    assign align_bad = (is_half && addr[0]) || (!is_byte && !is_half && addr[1:0] != 2'b00);
    assign mis_now   = align_bad || (in_mmio && (is_byte || is_half));
    assign unm_now   = !mis_now && !(in_inst || in_data || in_mmio);

    always_comb begin
        sel_now = SEL_NONE;
        if (!mis_now && !unm_now) begin
            if (in_inst)      sel_now = SEL_INST;
            else if (in_data) sel_now = SEL_DATA;
            else              sel_now = SEL_MMIO;
        end
    end

    always_comb begin
        byte_en    = 4'b1111;
        store_word = wr_data;
        if (is_byte) begin
            byte_en    = 4'b0001 << addr[1:0];
            store_word = {4{wr_data[7:0]}};
        end else if (is_half) begin
            byte_en    = addr[1] ? 4'b1100 : 4'b0011;
            store_word = {2{wr_data[15:0]}};
        end
    end

    assign inst_we = wr_ena && !rst && sel_now == SEL_INST;
    assign data_we = wr_ena && !rst && sel_now == SEL_DATA;
    assign leds_we = wr_ena && sel_now == SEL_MMIO && addr[3:2] == 2'b00;

    always_comb begin
        mmio_rd = 32'h0;
        case (addr[3:2])
            2'b00:   mmio_rd = {16'h0, leds};
            2'b01:   mmio_rd = cycles;
            default: mmio_rd = 32'h0;
        endcase
    end

    // Read-first RAMs: the registered word always holds pre-write contents.
    always_ff @(posedge clk) begin
        inst_word <= inst_mem[inst_idx];
        if (inst_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) inst_mem[inst_idx][8*b +: 8] <= store_word[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        data_word <= data_mem[data_idx];
        if (data_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) data_mem[data_idx][8*b +: 8] <= store_word[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            leds   <= 16'h0;
            cycles <= 32'h0;
        end else begin
            cycles <= cycles + 32'h1;
            if (leds_we) leds <= wr_data[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q      <= SEL_NONE;
            lane_q     <= 2'b00;
            funct3_q   <= 3'b000;
            mmio_word  <= 32'h0;
            misaligned <= 1'b0;
            unmapped   <= 1'b0;
        end else begin
            sel_q      <= sel_now;
            lane_q     <= addr[1:0];
            funct3_q   <= funct3;
            mmio_word  <= mmio_rd;
            misaligned <= mis_now;
            unmapped   <= unm_now;
        end
    end

    // A flagged access leaves sel_q at SEL_NONE, which forces rd_data to zero.
    always_comb begin
        logic [31:0] word_sel;
        logic [7:0]  lane_byte;
        logic [15:0] lane_half;
        word_sel = 32'h0;
        case (sel_q)
            SEL_INST: word_sel = inst_word;
            SEL_DATA: word_sel = data_word;
            SEL_MMIO: word_sel = mmio_word;
            default:  word_sel = 32'h0;
        endcase
        lane_byte = word_sel[8*lane_q +: 8];
        lane_half = lane_q[1] ? word_sel[31:16] : word_sel[15:0];
        case (funct3_q)
            3'b000:  rd_data = {{24{lane_byte[7]}}, lane_byte};
            3'b001:  rd_data = {{16{lane_half[15]}}, lane_half};
            3'b100:  rd_data = {24'h0, lane_byte};
            3'b101:  rd_data = {16'h0, lane_half};
            default: rd_data = word_sel;
        endcase
    end

endmodule

// File: tb/tb_rv32i_memory_unit.sv
// Directed, table-driven bench for rv32i_memory_unit with hand-written
// sequences for reset, mid-access reset and the cycle counter.
module tb_rv32i_memory_unit;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic        wr_ena;
    logic [2:0]  funct3;
    logic [31:0] rd_data;
    logic        misaligned;
    logic        unmapped;
    logic [15:0] leds;

    int total_checks;
    int passed_checks;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [2:0]  f3;
        logic        chk_rd;
        logic [31:0] rd;
        logic        mis;
        logic        unm;
        logic [15:0] leds;
    } vec_t;

    vec_t vecs [0:63];
    int   nvec;

    rv32i_memory_unit dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .wr_data    (wr_data),
        .wr_ena     (wr_ena),
        .funct3     (funct3),
        .rd_data    (rd_data),
        .misaligned (misaligned),
        .unmapped   (unmapped),
        .leds       (leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One access per call; outputs are sampled 1 time unit after the edge.
    task automatic applyStimulus(input logic r, input logic [31:0] a, input logic [31:0] wd,
                                 input logic we, input logic [2:0] f3);
        rst     = r;
        addr    = a;
        wr_data = wd;
        wr_ena  = we;
        funct3  = f3;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_checks++;
        if (actual === expected) passed_checks++;
        else $display("[TB] FAIL %s: got %08h, expected %08h", name, actual, expected);
    endtask

    task automatic addVec(input logic [31:0] a, input logic [31:0] wd, input logic we,
                          input logic [2:0] f3, input logic chk, input logic [31:0] rd,
                          input logic mis, input logic unm, input logic [15:0] l);
        vecs[nvec] = '{a, wd, we, f3, chk, rd, mis, unm, l};
        nvec++;
    endtask

    initial begin
        total_checks  = 0;
        passed_checks = 0;
        nvec          = 0;

        // addr, wr_data, we, funct3, check rd, rd, mis, unm, leds
        addVec(32'h0000_0000, 32'h0070_0093, 1, 3'b010, 0, 32'h0,         0, 0, 16'h0);
        addVec(32'h0000_0000, 32'h0,         0, 3'b010, 1, 32'h0070_0093, 0, 0, 16'h0);
        addVec(32'h0000_07FC, 32'hCAFE_F00D, 1, 3'b010, 0, 32'h0,         0, 0, 16'h0);
        addVec(32'h0000_07FC, 32'h0,         0, 3'b010, 1, 32'hCAFE_F00D, 0, 0, 16'h0);
        addVec(32'h0000_0800, 32'h0,         0, 3'b010, 1, 32'h0,         0, 1, 16'h0);
        addVec(32'h1000_0004, 32'h8000_00F0, 1, 3'b010, 0, 32'h0,         0, 0, 16'h0);
        addVec(32'h1000_0004, 32'h0,         0, 3'b000, 1, 32'hFFFF_FFF0, 0, 0, 16'h0);
        addVec(32'h1000_0004, 32'h0,         0, 3'b100, 1, 32'h0000_00F0, 0, 0, 16'h0);
        addVec(32'h1000_0006, 32'h0,         0, 3'b001, 1, 32'hFFFF_8000, 0, 0, 16'h0);
        addVec(32'h1000_0006, 32'h0,         0, 3'b101, 1, 32'h0000_8000, 0, 0, 16'h0);
        addVec(32'h1000_0004, 32'h0,         0, 3'b001, 1, 32'h0000_00F0, 0, 0, 16'h0);
        addVec(32'h1000_0008, 32'h1122_3344, 1, 3'b010, 0, 32'h0,         0, 0, 16'h0);
        addVec(32'h1000_000A, 32'h0000_00AA, 1, 3'b000, 1, 32'h0000_0022, 0, 0, 16'h0);
        addVec(32'h1000_0008, 32'h0,         0, 3'b010, 1, 32'h11AA_3344, 0, 0, 16'h0);
        addVec(32'h1000_000A, 32'h0,         0, 3'b001, 1, 32'h0000_11AA, 0, 0, 16'h0);
        addVec(32'h1000_000B, 32'h0,         0, 3'b000, 1, 32'h0000_0011, 0, 0, 16'h0);
        addVec(32'h1000_0009, 32'h0,         0, 3'b000, 1, 32'h0000_0033, 0, 0, 16'h0);
        addVec(32'h1000_0008, 32'h0,         0, 3'b100, 1, 32'h0000_0044, 0, 0, 16'h0);
        addVec(32'h1000_0008, 32'h0,         0, 3'b011, 1, 32'h11AA_3344, 0, 0, 16'h0);
        addVec(32'h1000_000A, 32'h0,         0, 3'b111, 1, 32'h0,         1, 0, 16'h0);
        addVec(32'h1000_0000, 32'h0000_0077, 1, 3'b010, 0, 32'h0,         0, 0, 16'h0);
        addVec(32'h1000_0000, 32'h0000_0005, 1, 3'b010, 1, 32'h0000_0077, 0, 0, 16'h0);
        addVec(32'h1000_0000, 32'h0,         0, 3'b010, 1, 32'h0000_0005, 0, 0, 16'h0);
        addVec(32'h1000_0002, 32'h0,         0, 3'b010, 1, 32'h0,         1, 0, 16'h0);
        addVec(32'h1000_0001, 32'hFFFF_FFFF, 1, 3'b010, 1, 32'h0,         1, 0, 16'h0);
        addVec(32'h1000_0003, 32'hFFFF_FFFF, 1, 3'b001, 1, 32'h0,         1, 0, 16'h0);
        addVec(32'h1000_0000, 32'h0,         0, 3'b010, 1, 32'h0000_0005, 0, 0, 16'h0);
        addVec(32'h2000_0000, 32'h0000_DEAD, 1, 3'b010, 1, 32'h0,         0, 1, 16'h0);
        addVec(32'h2000_0002, 32'h0,         0, 3'b010, 1, 32'h0,         1, 0, 16'h0);
        addVec(32'h1000_07FC, 32'h0BAD_BEEF, 1, 3'b010, 0, 32'h0,         0, 0, 16'h0);
        addVec(32'h1000_07FC, 32'h0,         0, 3'b010, 1, 32'h0BAD_BEEF, 0, 0, 16'h0);
        addVec(32'h1000_0800, 32'h0,         0, 3'b010, 1, 32'h0,         0, 1, 16'h0);
        addVec(32'hF000_0000, 32'hFFFF_ABCD, 1, 3'b010, 1, 32'h0,         0, 0, 16'hABCD);
        addVec(32'hF000_0000, 32'h0,         0, 3'b010, 1, 32'h0000_ABCD, 0, 0, 16'hABCD);
        addVec(32'hF000_0000, 32'h0000_0012, 1, 3'b000, 1, 32'h0,         1, 0, 16'hABCD);
        addVec(32'hF000_0002, 32'h0,         0, 3'b001, 1, 32'h0,         1, 0, 16'hABCD);
        addVec(32'hF000_0008, 32'h0,         0, 3'b010, 1, 32'h0,         0, 0, 16'hABCD);
        addVec(32'hF000_000C, 32'h0000_1234, 1, 3'b010, 1, 32'h0,         0, 0, 16'hABCD);
        addVec(32'hF000_0010, 32'h0,         0, 3'b010, 1, 32'h0,         0, 1, 16'hABCD);
        addVec(32'hF000_0004, 32'h0000_0000, 1, 3'b010, 0, 32'h0,         0, 0, 16'hABCD);
        addVec(32'h1000_0010, 32'h0000_1234, 1, 3'b010, 0, 32'h0,         0, 0, 16'hABCD);

        // Initial reset: outputs must come up zero.
        applyStimulus(1, 32'h0, 32'h0, 0, 3'b010);
        applyStimulus(1, 32'h0, 32'h0, 0, 3'b010);
        checkOutput("reset rd_data", rd_data, 32'h0);
        checkOutput("reset misaligned", 32'(misaligned), 32'h0);
        checkOutput("reset unmapped", 32'(unmapped), 32'h0);
        checkOutput("reset leds", 32'(leds), 32'h0);

        for (int i = 0; i < nvec; i++) begin
            applyStimulus(0, vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].f3);
            if (vecs[i].chk_rd) checkOutput($sformatf("vec%0d rd_data", i), rd_data, vecs[i].rd);
            checkOutput($sformatf("vec%0d misaligned", i), 32'(misaligned), 32'(vecs[i].mis));
            checkOutput($sformatf("vec%0d unmapped", i), 32'(unmapped), 32'(vecs[i].unm));
            checkOutput($sformatf("vec%0d leds", i), 32'(leds), 32'(vecs[i].leds));
        end

        // Reset during a store: write suppressed, registers cleared.
        applyStimulus(1, 32'h1000_0010, 32'h0000_FFFF, 1, 3'b010);
        checkOutput("midreset leds", 32'(leds), 32'h0);
        checkOutput("midreset rd_data", rd_data, 32'h0);
        checkOutput("midreset misaligned", 32'(misaligned), 32'h0);

        // Ten idle accesses after release, then the counter reads 10, then 11.
        for (int k = 0; k < 10; k++) applyStimulus(0, 32'h0, 32'h0, 0, 3'b010);
        applyStimulus(0, 32'hF000_0004, 32'h0, 0, 3'b010);
        checkOutput("cycles at 10", rd_data, 32'd10);
        applyStimulus(0, 32'hF000_0004, 32'h0, 0, 3'b010);
        checkOutput("cycles at 11", rd_data, 32'd11);

        applyStimulus(0, 32'h1000_0010, 32'h0, 0, 3'b010);
        checkOutput("store suppressed by reset", rd_data, 32'h0000_1234);
        applyStimulus(0, 32'hF000_0000, 32'h0, 0, 3'b010);
        checkOutput("leds reg after reset", rd_data, 32'h0);
        applyStimulus(0, 32'h0000_0000, 32'h0, 0, 3'b010);
        checkOutput("inst ram kept over reset", rd_data, 32'h0070_0093);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
